instr_fetch: RTL and testbench

//  Program-counter and fetch stage for the RAT MCU. Drives PROG_ADDR into the 1024x18

---
 rtl/rat_pkg.sv | 31 +++
 rtl/instr_fetch_if.sv | 26 ++
 rtl/fetch_skid_buf.sv | 51 +++++
 rtl/instr_fetch.sv | 58 +++++
 tb/tb_instr_fetch.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/rat_pkg.sv
// Shared types and constants for the RAT MCU fetch stage.
package rat_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned IR_W   = 18;

  localparam logic [ADDR_W-1:0] RESET_VEC = 10'h000;
  localparam logic [ADDR_W-1:0] INTR_VEC  = 10'h3FF;

  typedef enum logic [1:0] {
    PC_IMMED = 2'd0,
    PC_STACK = 2'd1,
    PC_INTR  = 2'd2,
    PC_RESET = 2'd3
  } pc_sel_t;

  function automatic logic [ADDR_W-1:0] pc_target(pc_sel_t           sel,
                                                  logic [ADDR_W-1:0] immed,
                                                  logic [ADDR_W-1:0] stack);
    logic [ADDR_W-1:0] tgt;
    tgt = RESET_VEC;
    unique case (sel)
      PC_IMMED: tgt = immed;
      PC_STACK: tgt = stack;
      PC_INTR:  tgt = INTR_VEC;
      PC_RESET: tgt = RESET_VEC;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: ROM port, redirect request and decoder-side instruction stream.
interface instr_fetch_if;
  import rat_pkg::*;

  logic [ADDR_W-1:0] prog_addr;
  logic [IR_W-1:0]   prog_ir;
  logic              pc_ld;
  pc_sel_t           pc_mux_sel;
  logic [ADDR_W-1:0] from_immed;
  logic [ADDR_W-1:0] from_stack;
  logic              stall;
  logic [IR_W-1:0]   ir_out;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_valid;

  modport master (
    output prog_addr, ir_out, ir_pc, ir_valid,
    input  prog_ir, pc_ld, pc_mux_sel, from_immed, from_stack, stall
  );

  modport slave (
    input  prog_addr, ir_out, ir_pc, ir_valid,
    output prog_ir, pc_ld, pc_mux_sel, from_immed, from_stack, stall
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry hold register that parks the ROM response while the decoder stalls.
module fetch_skid_buf
  import rat_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              rsp_valid_i,
  input  logic [IR_W-1:0]   rsp_ir_i,
  input  logic [ADDR_W-1:0] rsp_pc_i,
  output logic [IR_W-1:0]   ir_out_o,
  output logic [ADDR_W-1:0] ir_pc_o,
  output logic              ir_valid_o
);

  logic              hold_valid_q, hold_valid_d;
  logic [IR_W-1:0]   hold_ir_q, hold_ir_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_ir_d    = hold_ir_q;
    hold_pc_d    = hold_pc_q;
    if (flush_i || !stall_i) begin
      hold_valid_d = 1'b0;
    end else if (!hold_valid_q && rsp_valid_i) begin
      // ROM output changes next cycle; park the presented word so it stays stable.
      hold_valid_d = 1'b1;
      hold_ir_d    = rsp_ir_i;
      hold_pc_d    = rsp_pc_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_valid_q <= 1'b0;
      hold_ir_q    <= '0;
      hold_pc_q    <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_ir_q    <= hold_ir_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  assign ir_out_o   = hold_valid_q ? hold_ir_q : rsp_ir_i;
  assign ir_pc_o    = hold_valid_q ? hold_pc_q : rsp_pc_i;
  assign ir_valid_o = !rst_i && (hold_valid_q || rsp_valid_i);

endmodule

// File: rtl/instr_fetch.sv
// Program counter and fetch stage: drives the synchronous ROM and tags its response.
module instr_fetch
  import rat_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  instr_fetch_if.master bus
);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic              rsp_valid_q, rsp_valid_d;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_valid_d = rsp_valid_q;
    if (bus.pc_ld) begin
      fetch_pc_d  = pc_target(bus.pc_mux_sel, bus.from_immed, bus.from_stack);
      rsp_valid_d = 1'b0;
    end else begin
      // On stall the ROM re-reads fetch_pc, so the response tag still advances.
      if (!bus.stall) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      end
      rsp_pc_d    = fetch_pc_q;
      rsp_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc_q  <= RESET_VEC;
      rsp_pc_q    <= RESET_VEC;
      rsp_valid_q <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.prog_addr = fetch_pc_q;

  fetch_skid_buf u_skid (
    .clk_i       (CLK),
    .rst_i       (RST),
    .flush_i     (bus.pc_ld),
    .stall_i     (bus.stall),
    .rsp_valid_i (rsp_valid_q),
    .rsp_ir_i    (bus.prog_ir),
    .rsp_pc_i    (rsp_pc_q),
    .ir_out_o    (bus.ir_out),
    .ir_pc_o     (bus.ir_pc),
    .ir_valid_o  (bus.ir_valid)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a 1-cycle synchronous ROM model.
module tb_instr_fetch;
  import rat_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  instr_fetch_if bus ();

  instr_fetch dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [IR_W-1:0] rom_word(logic [ADDR_W-1:0] a);
    logic [IR_W-1:0] w;
    w = IR_W'(a);
    return w ^ 18'h2A5A;
  endfunction

  always_ff @(posedge clk) bus.prog_ir <= rom_word(bus.prog_addr);

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_instr(logic [ADDR_W-1:0] pc);
    check($sformatf("ir_valid@%0h", pc), 32'(bus.ir_valid), 32'd1);
    check($sformatf("ir_pc@%0h", pc), 32'(bus.ir_pc), 32'(pc));
    check($sformatf("ir_out@%0h", pc), 32'(bus.ir_out), 32'(rom_word(pc)));
  endtask

  task automatic expect_bubble(string tag);
    check(tag, 32'(bus.ir_valid), 32'd0);
  endtask

  // Unselected target inputs carry junk so a wrong mux leg shows up.
  task automatic redirect(pc_sel_t sel, logic [ADDR_W-1:0] tgt);
    bus.pc_ld      = 1'b1;
    bus.pc_mux_sel = sel;
    bus.from_immed = (sel == PC_IMMED) ? tgt : 10'h155;
    bus.from_stack = (sel == PC_STACK) ? tgt : 10'h2AA;
  endtask

  initial begin
    rst            = 1'b1;
    bus.pc_ld      = 1'b0;
    bus.pc_mux_sel = PC_IMMED;
    bus.from_immed = '0;
    bus.from_stack = '0;
    bus.stall      = 1'b0;

    // Reset, then sequential stream from RESET_VEC
    repeat (3) begin
      step();
      check("rst_valid", 32'(bus.ir_valid), 32'd0);
      check("rst_addr", 32'(bus.prog_addr), 32'd0);
    end
    rst = 1'b0;
    for (int p = 0; p <= 5; p++) begin
      step();
      expect_instr(ADDR_W'(p));
    end

    // Stall holds 5, then 6,7,... without gap or repeat
    bus.stall = 1'b1;
    repeat (4) begin
      step();
      expect_instr(10'h005);
    end
    bus.stall = 1'b0;
    for (int p = 6; p <= 16; p++) begin
      step();
      expect_instr(ADDR_W'(p));
    end

    // Branch: 0x011 squashed, one bubble, then 0x120
    redirect(PC_IMMED, 10'h120);
    step();
    expect_bubble("branch_bubble");
    bus.pc_ld = 1'b0;
    step();
    expect_instr(10'h120);
    step();
    expect_instr(10'h121);

    // Interrupt while stalled with a held word
    bus.stall = 1'b1;
    step();
    expect_instr(10'h121);
    redirect(PC_INTR, 10'h000);
    step();
    expect_bubble("intr_bubble");
    bus.pc_ld = 1'b0;
    bus.stall = 1'b0;
    step();
    expect_instr(10'h3FF);
    step();
    expect_instr(10'h000);
    step();
    expect_instr(10'h001);

    // Return, then back-to-back redirects where the last one wins
    redirect(PC_STACK, 10'h2B0);
    step();
    expect_bubble("ret_bubble");
    bus.pc_ld = 1'b0;
    step();
    expect_instr(10'h2B0);
    redirect(PC_IMMED, 10'h100);
    step();
    expect_bubble("ld1_bubble");
    redirect(PC_IMMED, 10'h200);
    step();
    expect_bubble("ld2_bubble");
    bus.pc_ld = 1'b0;
    step();
    expect_instr(10'h200);
    step();
    expect_instr(10'h201);

    // Reset during stall with a held word and a pending redirect
    bus.stall = 1'b1;
    step();
    expect_instr(10'h201);
    rst = 1'b1;
    redirect(PC_IMMED, 10'h050);
    step();
    check("rst2_valid", 32'(bus.ir_valid), 32'd0);
    check("rst2_addr", 32'(bus.prog_addr), 32'd0);
    rst       = 1'b0;
    bus.pc_ld = 1'b0;
    bus.stall = 1'b0;
    step();
    expect_instr(10'h000);
    step();
    expect_instr(10'h001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
